// File: rtl/sha3_digest_serializer_if.sv
// Word stream from the digest serializer: 32-bit data with valid/ready and an end-of-digest marker.
interface sha3_digest_serializer_if;
  logic [31:0] odata;
  logic        ovalid;
  logic        olast;
  logic        iready;

  modport master (output odata, output ovalid, output olast, input iready);
  modport slave  (input odata, input ovalid, input olast, output iready);
endinterface

// File: rtl/sha3_digest_serializer.sv
// Captures the final Keccak state on sample and streams the digest prefix as
// little-endian 32-bit words; a single digest is held, extra samples while busy are dropped.
module sha3_digest_serializer #(
  parameter int DIGEST_WORDS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [63:0]              isa [5],
  input  logic [63:0]              isb [5],
  input  logic [63:0]              isc [5],
  input  logic [63:0]              isd [5],
  input  logic [63:0]              ise [5],
  input  logic                     sample,
  output logic                     obusy,
  output logic                     odropped,
  sha3_digest_serializer_if.master bus
);
  localparam int         NLANES   = (DIGEST_WORDS + 1) / 2;
  localparam logic [3:0] LAST_IDX = 4'(DIGEST_WORDS - 1);

  if (!(DIGEST_WORDS == 7 || DIGEST_WORDS == 8 ||
        DIGEST_WORDS == 12 || DIGEST_WORDS == 16)) begin : g_bad_digest_words
    $error("sha3_digest_serializer: DIGEST_WORDS must be 7, 8, 12 or 16");
  end

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic        dropped_q, dropped_d;
  logic [63:0] lane_q  [NLANES];
  logic [63:0] lane_d  [NLANES];
  logic [63:0] lane_in [NLANES];
  logic        capture;
  logic        send;
  logic        last;
  logic        handshake;
  logic [63:0] lane_sel;
  logic [31:0] word;

  // Lane L lives in row L/5, element L%5.
  always_comb begin
    for (int l = 0; l < NLANES; l++) begin
      case (l / 5)
        0:       lane_in[l] = isa[l % 5];
        1:       lane_in[l] = isb[l % 5];
        2:       lane_in[l] = isc[l % 5];
        3:       lane_in[l] = isd[l % 5];
        default: lane_in[l] = ise[l % 5];
      endcase
    end
  end

  assign send      = (state_q == SEND);
  assign last      = send && (idx_q == LAST_IDX);
  assign handshake = send && bus.iready;

  always_comb begin
    lane_sel = '0;
    for (int l = 0; l < NLANES; l++) begin
      if (idx_q[3:1] == l[2:0]) lane_sel = lane_q[l];
    end
    word = idx_q[0] ? lane_sel[63:32] : lane_sel[31:0];
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    dropped_d = dropped_q;
    capture   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sample) begin
          capture = 1'b1;
          idx_d   = 4'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (handshake && last) begin
          idx_d = 4'd0;
          // A sample on the final beat reloads with no idle gap.
          if (sample) capture = 1'b1;
          else        state_d = IDLE;
        end else begin
          if (handshake) idx_d = idx_q + 4'd1;
          if (sample)    dropped_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int l = 0; l < NLANES; l++) begin
      lane_d[l] = capture ? lane_in[l] : lane_q[l];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= 4'd0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      dropped_q <= dropped_d;
    end
  end

  // Lane storage is pure data and is never cleared; it is only read while in SEND.
  always_ff @(posedge clk) begin
    for (int l = 0; l < NLANES; l++) begin
      lane_q[l] <= lane_d[l];
    end
  end

  assign bus.ovalid = send;
  assign bus.odata  = send ? word : 32'd0;
  assign bus.olast  = last;
  assign obusy      = send;
  assign odropped   = dropped_q;
endmodule

// File: tb/tb_sha3_digest_serializer.sv
// Runs 7/8/12/16-word serializers on shared stimulus against a digest-queue reference model.
module tb_sha3_digest_serializer;
  localparam int NDUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample;
  logic        iready;
  logic [63:0] lanes [25];
  logic [63:0] isa [5];
  logic [63:0] isb [5];
  logic [63:0] isc [5];
  logic [63:0] isd [5];
  logic [63:0] ise [5];

  logic [31:0] odata_a    [NDUT];
  logic        ovalid_a   [NDUT];
  logic        olast_a    [NDUT];
  logic        obusy_a    [NDUT];
  logic        odropped_a [NDUT];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int e = 0; e < 5; e++) begin
      isa[e] = lanes[e];
      isb[e] = lanes[5 + e];
      isc[e] = lanes[10 + e];
      isd[e] = lanes[15 + e];
      ise[e] = lanes[20 + e];
    end
  end

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int DW = (g == 0) ? 8 : (g == 1) ? 7 : (g == 2) ? 12 : 16;
    sha3_digest_serializer_if bus ();
    assign bus.iready = iready;
    sha3_digest_serializer #(.DIGEST_WORDS(DW)) dut (
      .clk      (clk),
      .rst      (rst),
      .isa      (isa),
      .isb      (isb),
      .isc      (isc),
      .isd      (isd),
      .ise      (ise),
      .sample   (sample),
      .obusy    (obusy_a[g]),
      .odropped (odropped_a[g]),
      .bus      (bus)
    );
    assign odata_a[g]  = bus.odata;
    assign ovalid_a[g] = bus.ovalid;
    assign olast_a[g]  = bus.olast;
  end

  function automatic int dw_of(int d);
    case (d)
      0:       return 8;
      1:       return 7;
      2:       return 12;
      default: return 16;
    endcase
  endfunction

  // Reference: each DUT owns a list of words still owed ({last, data}); empty means idle.
  logic [32:0] mq    [NDUT][16];
  int          mh    [NDUT];
  int          mt    [NDUT];
  bit          mdrop [NDUT];
  bit          armed = 1'b0;

  task automatic chk(input string nm, input int d, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL dut%0d(DW=%0d) %s got=%h expected=%h at t=%0t", d, dw_of(d), nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    bit          ne;
    bit          fin;
    logic [63:0] ln;
    if (armed) begin
      for (int d = 0; d < NDUT; d++) begin
        ne = (mh[d] < mt[d]);
        chk("ovalid",   d, 32'(ovalid_a[d]),   32'(ne));
        chk("obusy",    d, 32'(obusy_a[d]),    32'(ne));
        chk("odropped", d, 32'(odropped_a[d]), 32'(mdrop[d]));
        chk("olast",    d, 32'(olast_a[d]),    ne ? 32'(mq[d][mh[d]][32]) : 32'd0);
        chk("odata",    d, odata_a[d],         ne ? mq[d][mh[d]][31:0] : 32'd0);
      end
    end
    for (int d = 0; d < NDUT; d++) begin
      if (rst) begin
        mh[d] = 0; mt[d] = 0; mdrop[d] = 1'b0;
      end else begin
        ne  = (mh[d] < mt[d]);
        fin = 1'b0;
        if (ne && iready) begin
          fin = mq[d][mh[d]][32];
          mh[d]++;
        end
        if (sample) begin
          if (!ne || fin) begin
            for (int k = 0; k < dw_of(d); k++) begin
              ln = lanes[k / 2];
              mq[d][k] = {k == dw_of(d) - 1, (k % 2 == 1) ? ln[63:32] : ln[31:0]};
            end
            mh[d] = 0;
            mt[d] = dw_of(d);
          end else begin
            mdrop[d] = 1'b1;
          end
        end
      end
    end
    if (rst) armed = 1'b1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_lanes();
    for (int l = 0; l < 25; l++) lanes[l] = {$urandom, $urandom};
  endtask

  task automatic pulse_sample();
    sample = 1'b1;
    step();
    sample = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sample = 1'b0; iready = 1'b0;
    rand_lanes();
    step();
    step();
    rst = 1'b0;
    step();

    // Empty-message SHA3-256 final state, lane 0 only matters for word 0/1.
    lanes[0] = 64'h66d71ebff8c6ffa7;
    iready = 1'b1;
    pulse_sample();
    repeat (20) step();

    // Backpressure with counting lane pattern, once stall-free then twice stalled.
    for (int l = 0; l < 25; l++) lanes[l] = 64'h0123456789abcdef + 64'(l);
    iready = 1'b1;
    pulse_sample();
    repeat (18) step();
    for (int r = 0; r < 2; r++) begin
      iready = 1'($urandom_range(0, 1));
      pulse_sample();
      for (int c = 0; c < 50; c++) begin
        iready = 1'($urandom_range(0, 1));
        step();
      end
    end
    iready = 1'b1;
    repeat (18) step();

    // Drop while busy at beat 3.
    rand_lanes();
    pulse_sample();
    step(); step();
    rand_lanes();
    pulse_sample();
    repeat (20) step();

    // Seamless reload on the final handshake of the 8-word digest.
    rst = 1'b1; step(); rst = 1'b0;
    rand_lanes();
    pulse_sample();
    repeat (7) step();
    rand_lanes();
    pulse_sample();
    repeat (20) step();

    // Reset mid-stream with sample asserted in the reset cycle.
    rand_lanes();
    pulse_sample();
    repeat (4) step();
    rand_lanes();
    rst = 1'b1; sample = 1'b1;
    step();
    rst = 1'b0; sample = 1'b0;
    repeat (3) step();
    rand_lanes();
    pulse_sample();
    repeat (20) step();

    // Random soak.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) rand_lanes();
      sample = ($urandom_range(0, 7) == 0);
      iready = 1'($urandom_range(0, 1));
      rst    = ($urandom_range(0, 149) == 0);
      step();
    end
    rst = 1'b0; sample = 1'b0; iready = 1'b1;
    repeat (25) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
